// File: rtl/settings_bus_arbiter.sv
// Round-robin arbiter for a shared settings bus. One requester's write is
// latched, presented for a single strobe cycle, then the bus idles for GAP
// cycles. A per-requester lock holds the round-robin pointer for bursts.
module settings_bus_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned AWIDTH  = 8,
  parameter int unsigned GAP     = 1,
  parameter int unsigned IDW     = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*AWIDTH-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0]     req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      set_stb,
  output logic [AWIDTH-1:0]         set_addr,
  output logic [31:0]               set_data,
  output logic [IDW-1:0]            grant_id,
  output logic                      busy,
  output logic [15:0]               stb_count
);

  typedef enum logic [1:0] {StIdle, StIssue, StGap} state_e;

  state_e              state_q, state_d;
  logic [IDW-1:0]      ptr_q, ptr_d;
  logic [3:0]          gap_cnt_q, gap_cnt_d;
  logic                set_stb_q, set_stb_d;
  logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
  logic [AWIDTH-1:0]   set_addr_q, set_addr_d;
  logic [31:0]         set_data_q, set_data_d;
  logic [IDW-1:0]      grant_id_q, grant_id_d;
  logic [15:0]         stb_count_q;

  logic                sel_found;
  logic [IDW-1:0]      sel_idx;
  logic [IDW-1:0]      cand;

  // First valid requester at or above ptr, wrapping modulo NUM_REQ.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IDW'((32'(ptr_q) + i) % NUM_REQ);
      if (!sel_found && req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Next-state, pointer and registered-output logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gap_cnt_d   = gap_cnt_q;
    set_stb_d   = 1'b0;
    req_ready_d = '0;
    set_addr_d  = set_addr_q;
    set_data_d  = set_data_q;
    grant_id_d  = grant_id_q;
    unique case (state_q)
      StIdle: begin
        if (sel_found) begin
          state_d              = StIssue;
          set_stb_d            = 1'b1;
          req_ready_d[sel_idx] = 1'b1;
          set_addr_d           = req_addr[sel_idx*AWIDTH +: AWIDTH];
          set_data_d           = req_data[sel_idx*32 +: 32];
          grant_id_d           = sel_idx;
        end
      end
      StIssue: begin
        // A locked grantee keeps the pointer so it wins the next decision again.
        if (!req_lock[grant_id_q]) begin
          ptr_d = IDW'((32'(grant_id_q) + 32'd1) % NUM_REQ);
        end
        if (GAP > 0) begin
          state_d   = StGap;
          gap_cnt_d = 4'(GAP - 1);
        end else begin
          state_d = StIdle;
        end
      end
      StGap: begin
        if (gap_cnt_q == 4'd0) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; strobe count advances once per ISSUE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      gap_cnt_q   <= '0;
      set_stb_q   <= 1'b0;
      req_ready_q <= '0;
      set_addr_q  <= '0;
      set_data_q  <= '0;
      grant_id_q  <= '0;
      stb_count_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gap_cnt_q   <= gap_cnt_d;
      set_stb_q   <= set_stb_d;
      req_ready_q <= req_ready_d;
      set_addr_q  <= set_addr_d;
      set_data_q  <= set_data_d;
      grant_id_q  <= grant_id_d;
      if (state_q == StIssue) begin
        stb_count_q <= stb_count_q + 16'd1;
      end
    end
  end

  assign set_stb   = set_stb_q;
  assign req_ready = req_ready_q;
  assign set_addr  = set_addr_q;
  assign set_data  = set_data_q;
  assign grant_id  = grant_id_q;
  assign busy      = (state_q != StIdle);
  assign stb_count = stb_count_q;

endmodule

// File: tb/tb_settings_bus_arbiter.sv
// Self-checking bench for settings_bus_arbiter: table of single-grant vectors
// plus hand sequences for round-robin streaming, lock bursts, reset during a
// strobe and counter wrap. Expected strobes are queued and checked on set_stb.
module tb_settings_bus_arbiter;

  localparam int NR = 4;
  localparam int AW = 8;
  localparam int GP = 1;

  logic             clk;
  logic             rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_lock;
  logic [NR*AW-1:0] req_addr;
  logic [NR*32-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             set_stb;
  logic [AW-1:0]    set_addr;
  logic [31:0]      set_data;
  logic [1:0]       grant_id;
  logic             busy;
  logic [15:0]      stb_count;

  logic [AW-1:0]    addr_r [NR];
  logic [31:0]      data_r [NR];

  typedef struct {
    int          g;
    logic [7:0]  a;
    logic [31:0] d;
    logic [15:0] cnt;
  } exp_t;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] lock;
    int         g;
  } vec_t;

  exp_t        sbq[$];
  int          errors;
  int          checks;
  logic [15:0] cnt_model;
  longint      cyc;

  settings_bus_arbiter #(
    .NUM_REQ(NR),
    .AWIDTH (AW),
    .GAP    (GP),
    .IDW    (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_lock (req_lock),
    .req_addr (req_addr),
    .req_data (req_data),
    .req_ready(req_ready),
    .set_stb  (set_stb),
    .set_addr (set_addr),
    .set_data (set_data),
    .grant_id (grant_id),
    .busy     (busy),
    .stb_count(stb_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  always_comb begin
    req_addr = '0;
    req_data = '0;
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW] = addr_r[i];
      req_data[i*32 +: 32] = data_r[i];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Scoreboard: each strobe must match the oldest queued expectation.
  initial begin
    exp_t       e;
    logic [3:0] oh;
    forever begin
      @(negedge clk);
      if (rst_n && set_stb) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_stb: got strobe to addr %0h, required none", set_addr);
        end else begin
          e  = sbq.pop_front();
          oh = 4'b0001 << e.g;
          check("grant_id", 64'(grant_id), 64'(e.g));
          check("set_addr", 64'(set_addr), 64'(e.a));
          check("set_data", 64'(set_data), 64'(e.d));
          check("req_ready", 64'(req_ready), 64'(oh));
          check("stb_count_in_issue", 64'(stb_count), 64'(e.cnt));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1);
  end

  task automatic expect_grant(input int g);
    exp_t e;
    e.g   = g;
    e.a   = addr_r[g];
    e.d   = data_r[g];
    e.cnt = cnt_model;
    cnt_model = cnt_model + 16'd1;
    sbq.push_back(e);
  endtask

  task automatic new_word(input int g);
    addr_r[g] = addr_r[g] + 8'h11;
    data_r[g] = $urandom;
  endtask

  // Returns in the ISSUE cycle (#1 after its rising edge) or flags a timeout.
  task automatic wait_stb(input int max, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < max && !ok) begin
      @(posedge clk);
      #1;
      n++;
      if (set_stb) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL stb_timeout: no strobe within %0d cycles, required one", max);
    end
  endtask

  // Called in the ISSUE cycle; counts busy cycles including that one.
  task automatic wait_idle(output int b);
    b = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (!busy) break;
      b++;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_set_stb"}, 64'(set_stb), 64'd0);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_set_addr"}, 64'(set_addr), 64'd0);
    check({tag, "_set_data"}, 64'(set_data), 64'd0);
    check({tag, "_grant_id"}, 64'(grant_id), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_stb_count"}, 64'(stb_count), 64'd0);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_lock  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    cnt_model = '0;
  endtask

  initial begin
    vec_t vecs[10];
    int   n;
    int   b;
    bit   ok;
    int   order[5];
    longint prev;

    errors    = 0;
    checks    = 0;
    cnt_model = '0;
    for (int i = 0; i < NR; i++) begin
      addr_r[i] = 8'h10 + 8'(i);
      data_r[i] = $urandom;
    end
    data_r[2] = 32'hDEADBEEF;

    // Pointer trace noted per row: ptr before -> grant -> ptr after.
    vecs[0] = '{valid: 4'b0100, lock: 4'b0000, g: 2};  // 0 -> 2 -> 3
    vecs[1] = '{valid: 4'b0011, lock: 4'b0000, g: 0};  // 3 -> 0 -> 1
    vecs[2] = '{valid: 4'b0011, lock: 4'b0000, g: 1};  // 1 -> 1 -> 2
    vecs[3] = '{valid: 4'b1001, lock: 4'b0000, g: 3};  // 2 -> 3 -> 0
    vecs[4] = '{valid: 4'b1111, lock: 4'b0000, g: 0};  // 0 -> 0 -> 1
    vecs[5] = '{valid: 4'b1000, lock: 4'b1000, g: 3};  // 1 -> 3 -> 1 (locked)
    vecs[6] = '{valid: 4'b0011, lock: 4'b0000, g: 1};  // 1 -> 1 -> 2
    vecs[7] = '{valid: 4'b0010, lock: 4'b1000, g: 1};  // lock on idle req 3
    vecs[8] = '{valid: 4'b0101, lock: 4'b0000, g: 2};  // 2 -> 2 -> 3
    vecs[9] = '{valid: 4'b0011, lock: 4'b0000, g: 0};  // 3 -> 0 -> 1

    do_reset();
    #1;
    check_reset_vals("rst");

    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      req_lock = vecs[k].lock;
      expect_grant(vecs[k].g);
      req_valid = vecs[k].valid;
      wait_stb(10, n, ok);
      if (ok) begin
        check("latency", 64'(n), 64'd1);
        req_valid = '0;
        new_word(vecs[k].g);
        wait_idle(b);
        check("busy_cycles", 64'(b), 64'(1 + GP));
        if (k == 0) begin
          check("single_grant_id", 64'(grant_id), 64'd2);
          check("single_stb_count", 64'(stb_count), 64'd1);
          check("single_addr_hold", 64'(set_addr), 64'h12);
        end
      end
      req_lock = '0;
    end

    // All four requesting continuously.
    do_reset();
    order = '{0, 1, 2, 3, 0};
    prev  = 0;
    for (int k = 0; k < 5; k++) begin
      expect_grant(order[k]);
      if (k == 0) req_valid = 4'b1111;
      wait_stb(10, n, ok);
      if (ok) begin
        if (k > 0) check("stb_spacing", 64'(cyc - prev), 64'(2 + GP));
        prev = cyc;
        new_word(order[k]);
      end
    end
    req_valid = '0;
    wait_idle(b);

    // Lock burst from req 1 while 0 and 2 compete; ptr first moved to 1.
    do_reset();
    expect_grant(0);
    req_valid = 4'b0001;
    wait_stb(10, n, ok);
    req_valid = '0;
    new_word(0);
    wait_idle(b);
    @(negedge clk);
    req_lock = 4'b0010;
    expect_grant(1);
    req_valid = 4'b0111;
    for (int k = 0; k < 3; k++) begin
      wait_stb(10, n, ok);
      new_word(1);
      if (k < 2) begin
        expect_grant(1);
      end else begin
        req_valid[1] = 1'b0;
        req_lock[1]  = 1'b0;
      end
    end
    expect_grant(2);
    wait_stb(10, n, ok);
    req_valid[2] = 1'b0;
    new_word(2);
    expect_grant(0);
    wait_stb(10, n, ok);
    req_valid[0] = 1'b0;
    new_word(0);
    wait_idle(b);

    // Reset asserted in the middle of an ISSUE cycle; the write is lost.
    @(negedge clk);
    req_valid = 4'b0100;
    wait_stb(10, n, ok);
    #1;
    rst_n = 1'b0;
    req_valid = '0;
    #1;
    check_reset_vals("midop");
    @(negedge clk);
    rst_n     = 1'b1;
    cnt_model = '0;
    @(negedge clk);
    expect_grant(3);
    req_valid = 4'b1000;
    wait_stb(10, n, ok);
    check("post_reset_grant", 64'(grant_id), 64'd3);
    req_valid = '0;
    new_word(3);
    wait_idle(b);

    // Counter wrap: preload the count as if 65535 strobes had been issued.
    @(negedge clk);
    dut.stb_count_q = 16'hFFFF;
    cnt_model       = 16'hFFFF;
    @(negedge clk);
    expect_grant(2);
    req_valid = 4'b0100;
    wait_stb(10, n, ok);
    req_valid = '0;
    wait_idle(b);
    check("stb_count_wrap", 64'(stb_count), 64'h0000);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 64'(sbq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
